multi_switch_debounce_ctrl: RTL

- Debounce scheduler for a bank of N raw switches. One shared tick timer drives N compact per-channel debounce FSMs.
- Each confirmed level change becomes a press/release event. A round-robin arbiter drains the events onto a single valid/ready event port.
- Sits between the board switches and the control logic. It replaces per-switch standalone debouncers and their private ~10 ms timers.

---
 rtl/multi_switch_debounce_ctrl.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_switch_debounce_ctrl.sv
// multi_switch_debounce_ctrl: debounce scheduler for a bank of raw switches.
// One shared tick timer paces N small per-channel debounce FSMs; confirmed
// level changes are posted as events and drained round-robin onto a single
// valid/ready event port.
module multi_switch_debounce_ctrl #(
  parameter int unsigned N_SW         = 4,
  parameter int unsigned TICK_BITS    = 19,
  parameter int unsigned STABLE_TICKS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_SW-1:0]         sw,
  output logic [N_SW-1:0]         db,
  output logic                    tick,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [$clog2(N_SW)-1:0] evt_id,
  output logic                    evt_level,
  output logic                    evt_overrun
);

  localparam int unsigned ID_W    = $clog2(N_SW);
  localparam logic [2:0]  CNT_MAX = 3'(STABLE_TICKS - 1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_WAIT   = 1'b1
  } ch_state_e;

  // ---------------------------------------------------------------------------
  // Input synchronisers and shared tick timer
  // ---------------------------------------------------------------------------
  logic [N_SW-1:0]      sync1_q;
  logic [N_SW-1:0]      s_q;
  logic [TICK_BITS-1:0] tick_cnt_q;

  // Two-flop synchroniser per switch bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      s_q     <= '0;
    end else begin
      sync1_q <= sw;
      s_q     <= sync1_q;
    end
  end

  // Free-running tick counter; wraps silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  // Tick is the all-ones count of the shared timer.
  always_comb begin
    tick = &tick_cnt_q;
  end

  // ---------------------------------------------------------------------------
  // Per-channel debounce FSMs
  // ---------------------------------------------------------------------------
  ch_state_e       state_q [N_SW];
  ch_state_e       state_d [N_SW];
  logic [2:0]      cnt_q   [N_SW];
  logic [2:0]      cnt_d   [N_SW];
  logic [N_SW-1:0] db_q;
  logic [N_SW-1:0] db_d;
  logic [N_SW-1:0] post;

  // Channel state, tick count and debounced level registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_SW; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
      db_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_SW; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      db_q <= db_d;
    end
  end

  // Next state: enter WAIT on mismatch, leave on match or on the final tick.
  always_comb begin
    db_d = db_q ^ post;
    for (int unsigned i = 0; i < N_SW; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_STABLE: begin
          cnt_d[i] = '0;
          if (s_q[i] != db_q[i]) begin
            state_d[i] = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (s_q[i] == db_q[i]) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] == CNT_MAX) begin
              state_d[i] = ST_STABLE;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 3'd1;
            end
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Outputs: a post fires on the tick that completes the mismatch window.
  always_comb begin
    post = '0;
    for (int unsigned i = 0; i < N_SW; i++) begin
      post[i] = (state_q[i] == ST_WAIT) && (s_q[i] != db_q[i]) &&
                tick && (cnt_q[i] == CNT_MAX);
    end
  end

  always_comb begin
    db = db_q;
  end

  // ---------------------------------------------------------------------------
  // Event pending bits and round-robin arbiter
  // ---------------------------------------------------------------------------
  logic [N_SW-1:0] pend_q;
  logic [N_SW-1:0] pend_d;
  logic [N_SW-1:0] lvl_q;
  logic [N_SW-1:0] lvl_d;
  logic [N_SW-1:0] ovr_q;
  logic [N_SW-1:0] ovr_d;
  logic [ID_W-1:0] last_q;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_found;
  logic            load;
  logic [N_SW-1:0] gnt_vec;

  logic            valid_q;
  logic [ID_W-1:0] id_q;
  logic            level_q;
  logic            overrun_q;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_id    = last_q;
    for (int unsigned k = 1; k <= N_SW; k++) begin
      idx = (int'(last_q) + k) % N_SW;
      if (!gnt_found && pend_q[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
  end

  // Grant decode: the output register only loads when empty or being drained.
  always_comb begin
    load    = !valid_q || evt_ready;
    gnt_vec = '0;
    for (int unsigned i = 0; i < N_SW; i++) begin
      gnt_vec[i] = load && gnt_found && (gnt_id == ID_W'(i));
    end
  end

  // Pending-event update; a post beats a same-cycle grant, which already
  // captured the old level/overrun, so the fresh post starts with ovr=0.
  always_comb begin
    pend_d = pend_q;
    lvl_d  = lvl_q;
    ovr_d  = ovr_q;
    for (int unsigned i = 0; i < N_SW; i++) begin
      if (post[i]) begin
        pend_d[i] = 1'b1;
        lvl_d[i]  = db_d[i];
        ovr_d[i]  = pend_q[i] && !gnt_vec[i];
      end else if (gnt_vec[i]) begin
        pend_d[i] = 1'b0;
        ovr_d[i]  = 1'b0;
      end
    end
  end

  // Pending bits and arbitration pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      lvl_q  <= '0;
      ovr_q  <= '0;
      last_q <= ID_W'(N_SW - 1);
    end else begin
      pend_q <= pend_d;
      lvl_q  <= lvl_d;
      ovr_q  <= ovr_d;
      if (load && gnt_found) begin
        last_q <= gnt_id;
      end
    end
  end

  // Event output register; held while valid and not accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      id_q      <= '0;
      level_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (load) begin
      valid_q <= gnt_found;
      if (gnt_found) begin
        id_q      <= gnt_id;
        level_q   <= lvl_q[gnt_id];
        overrun_q <= ovr_q[gnt_id];
      end
    end
  end

  // Drive event port from the output register.
  always_comb begin
    evt_valid   = valid_q;
    evt_id      = id_q;
    evt_level   = level_q;
    evt_overrun = overrun_q;
  end

endmodule
